// File: rtl/idct_out_collect_if.sv
// Output word stream of idct_out_collect: packed pixels with mode/last tags
// over a valid/ready handshake.
interface idct_out_collect_if #(
    parameter int W = 32
);
    logic [W-1:0] word_out;
    logic         word_valid;
    logic         word_ready;
    logic         word_mode;
    logic         word_last;

    modport master (
        output word_out,
        output word_valid,
        output word_mode,
        output word_last,
        input  word_ready
    );

    modport slave (
        input  word_out,
        input  word_valid,
        input  word_mode,
        input  word_last,
        output word_ready
    );
endinterface

// File: rtl/idct_out_collect.sv
// Ping-pong collector for IDCT 8x8 output blocks, re-emitted as packed words.
// Define IDCT_OUT_TRANSPOSE_EN to read blocks column-major.
module idct_out_collect #(
    parameter int PIX_W    = 8,
    parameter int WORD_PIX = 4,
    parameter int BLK_PIX  = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [PIX_W-1:0] pix_in,
    input  logic             pix_start_in,
    input  logic             pix_mode_in,
    idct_out_collect_if.master wbus,
    output logic             overflow
);
    localparam int AW    = $clog2(BLK_PIX);
    localparam int WORDS = BLK_PIX / WORD_PIX;
    localparam int IW    = $clog2(WORDS);
    localparam int JW    = $clog2(WORD_PIX);

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        DROP
    } wr_state_t;

    wr_state_t         state;
    logic [AW-1:0]     cnt;
    logic              wr_bank;
    logic              rd_bank;
    logic [1:0]        full;
    logic [1:0]        mode_bank;
    logic [IW-1:0]     rd_idx;

    logic [PIX_W-1:0]  mem [2*BLK_PIX];

    logic                      we;
    logic [AW-1:0]             waddr;
    logic                      done;
    logic                      accept;
    logic                      last_acc;
    logic [1:0]                full_set;
    logic [1:0]                full_clr;
    logic [IW-1:0]             nxt_idx;
    logic [PIX_W*WORD_PIX-1:0] rd_word;

    always_comb begin
        we    = 1'b0;
        waddr = '0;
        unique case (state)
            FILL: begin
                we    = 1'b1;
                waddr = pix_start_in ? '0 : cnt;
            end
            default: begin
                we = pix_start_in & ~full[wr_bank];
            end
        endcase
    end

    assign done     = (state == FILL) & ~pix_start_in
                    & (cnt == AW'(BLK_PIX - 1));
    assign accept   = wbus.word_valid & wbus.word_ready;
    assign last_acc = accept & wbus.word_last;
    assign full_set = done ? (2'b01 << wr_bank) : 2'b00;
    assign full_clr = last_acc ? (2'b01 << rd_bank) : 2'b00;
    assign nxt_idx  = wbus.word_valid ? rd_idx + 1'b1 : '0;

    // Gather the next word so it can be registered on load.
    always_comb begin
        logic [AW-1:0] a;
        rd_word = '0;
        for (int j = 0; j < WORD_PIX; j++) begin
`ifdef IDCT_OUT_TRANSPOSE_EN
            a = {nxt_idx[0], JW'(j), nxt_idx[IW-1:1]};
`else
            a = {nxt_idx, JW'(j)};
`endif
            rd_word[j*PIX_W +: PIX_W] = mem[{rd_bank, a}];
        end
    end

    // Pixel storage is deliberately not reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[{wr_bank, waddr}] <= pix_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            cnt             <= '0;
            wr_bank         <= 1'b0;
            rd_bank         <= 1'b0;
            full            <= 2'b00;
            mode_bank       <= 2'b00;
            rd_idx          <= '0;
            overflow        <= 1'b0;
            wbus.word_out   <= '0;
            wbus.word_valid <= 1'b0;
            wbus.word_mode  <= 1'b0;
            wbus.word_last  <= 1'b0;
        end else begin
            full <= (full & ~full_clr) | full_set;

            unique case (state)
                FILL: begin
                    if (pix_start_in) begin
                        cnt                <= AW'(1);
                        mode_bank[wr_bank] <= pix_mode_in;
                    end else if (done) begin
                        cnt     <= '0;
                        wr_bank <= ~wr_bank;
                        state   <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    if (pix_start_in) begin
                        cnt <= AW'(1);
                        if (!full[wr_bank]) begin
                            mode_bank[wr_bank] <= pix_mode_in;
                            state              <= FILL;
                        end else begin
                            overflow <= 1'b1;
                            state    <= DROP;
                        end
                    end else if (state == DROP) begin
                        if (cnt == AW'(BLK_PIX - 1)) begin
                            cnt   <= '0;
                            state <= IDLE;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
            endcase

            // Read side: a bank switch always costs one idle cycle.
            if (last_acc) begin
                wbus.word_valid <= 1'b0;
                wbus.word_last  <= 1'b0;
                rd_bank         <= ~rd_bank;
            end else if (accept ||
                         (!wbus.word_valid && full[rd_bank])) begin
                wbus.word_out   <= rd_word;
                wbus.word_valid <= 1'b1;
                wbus.word_mode  <= mode_bank[rd_bank];
                wbus.word_last  <= (nxt_idx == IW'(WORDS - 1));
                rd_idx          <= nxt_idx;
            end
        end
    end
endmodule

// File: tb/tb_idct_out_collect.sv
// Scoreboard bench for idct_out_collect: directed blocks, queue of expected
// words, negedge monitor checking each accepted and each stalled word.
module tb_idct_out_collect;
    typedef struct packed {
        logic [31:0] w;
        logic        m;
        logic        l;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] pix_in = '0;
    logic       pix_start_in = 1'b0;
    logic       pix_mode_in = 1'b0;
    logic       overflow;

    idct_out_collect_if #(.W(32)) bus ();

    idct_out_collect dut (
        .clk          (clk),
        .rst          (rst),
        .pix_in       (pix_in),
        .pix_start_in (pix_start_in),
        .pix_mode_in  (pix_mode_in),
        .wbus         (bus),
        .overflow     (overflow)
    );

    always #5 clk = ~clk;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   accepted = 0;
    int   rdy_mode = 0;
    int   cyc = 0;
    bit   stalled = 1'b0;
    exp_t held;

    function automatic void chk(string name, logic [32:0] act,
                                logic [32:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t",
                     name, act, exp, $time);
        end
    endfunction

    function automatic logic [31:0] exp_word(logic [7:0] base, int k);
        logic [31:0] w;
        int          r;
        int          c;
        w = '0;
        for (int j = 0; j < 4; j++) begin
`ifdef IDCT_OUT_TRANSPOSE_EN
            c = k / 2;
            r = (k % 2) * 4;
            w[j*8 +: 8] = base + 8'((r + j) * 8 + c);
`else
            w[j*8 +: 8] = base + 8'(4 * k + j);
`endif
        end
        return w;
    endfunction

    // Ready pattern: 0 = low, 1 = high, 2 = one cycle in three.
    initial begin
        bus.word_ready = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            cyc++;
            case (rdy_mode)
                0: bus.word_ready = 1'b0;
                1: bus.word_ready = 1'b1;
                default: bus.word_ready = (cyc % 3 == 0);
            endcase
        end
    end

    // Monitor
    always @(negedge clk) begin
        exp_t cur;
        exp_t e;
        cur = '{bus.word_out, bus.word_mode, bus.word_last};
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (bus.word_valid && stalled)
                chk("hold", {1'b0, cur}, {1'b0, held});
            if (bus.word_valid && bus.word_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_word", {1'b0, cur}, 33'h1_ffff_ffff);
                end else begin
                    e = sb.pop_front();
                    chk("word", {1'b0, cur}, {1'b0, e});
                end
                accepted++;
            end
            stalled = bus.word_valid && !bus.word_ready;
            held    = cur;
        end
    end

    task automatic send_block(input logic [7:0] base, input logic mode,
                              input int n, input bit expect_out);
        if (expect_out) begin
            for (int k = 0; k < 16; k++)
                sb.push_back('{exp_word(base, k), mode, (k == 15)});
        end
        for (int i = 0; i < n; i++) begin
            pix_in       = base + 8'(i);
            pix_start_in = (i == 0);
            pix_mode_in  = mode;
            @(posedge clk);
            #1;
        end
        pix_start_in = 1'b0;
    endtask

    task automatic drain(string name);
        int n = 0;
        while (sb.size() != 0 && n < 3000) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk(name, 33'(sb.size()), 33'd0);
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("rst_word", {1'b0, bus.word_out}, 33'd0);
        chk("rst_valid", 33'(bus.word_valid), 33'd0);
        chk("rst_mode", 33'(bus.word_mode), 33'd0);
        chk("rst_last", 33'(bus.word_last), 33'd0);
        chk("rst_ovf", 33'(overflow), 33'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Ramp, ready high
        rdy_mode = 1;
        send_block(8'h00, 1'b1, 64, 1'b1);
        drain("t1_drain");

        // Backpressure
        rdy_mode = 2;
        send_block(8'h00, 1'b0, 64, 1'b1);
        drain("t2_drain");

        // Restart in mid-block
        rdy_mode = 1;
        send_block(8'h40, 1'b1, 20, 1'b0);
        send_block(8'h80, 1'b0, 64, 1'b1);
        drain("t4_drain");
        chk("t4_ovf", 33'(overflow), 33'd0);

        // Both banks full: third block dropped
        rdy_mode = 0;
        send_block(8'h00, 1'b0, 64, 1'b1);
        send_block(8'h40, 1'b1, 64, 1'b1);
        chk("t3_valid_stalled", 33'(bus.word_valid), 33'd1);
        rdy_mode = 1;
        send_block(8'hC0, 1'b0, 64, 1'b0);
        drain("t3_drain");
        chk("t3_ovf", 33'(overflow), 33'd1);

        // Reset while word 7 is stalled
        accepted = 0;
        send_block(8'h10, 1'b1, 64, 1'b1);
        n = 0;
        while (accepted < 7 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        rdy_mode = 0;
        chk("t5_reach_w7", 33'(accepted), 33'd7);
        repeat (2) @(posedge clk);
        #1;
        chk("t5_w7", {1'b0, bus.word_out}, {1'b0, exp_word(8'h10, 7)});
        rst = 1'b1;
        @(negedge clk);
        chk("t5_valid", 33'(bus.word_valid), 33'd0);
        chk("t5_ovf", 33'(overflow), 33'd0);
        chk("t5_word", {1'b0, bus.word_out}, 33'd0);
        sb.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk);
        #1;
        rdy_mode = 1;
        send_block(8'h55, 1'b0, 64, 1'b1);
        drain("t5_drain");
        chk("final_valid", 33'(bus.word_valid), 33'd0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 n_cmp, n_fail);
        $finish;
    end
endmodule
